// File: rtl/ooo_read_responder.sv
`default_nettype none
// ============================================================================
// Module : ooo_read_responder
// Desc   : AR/R read slave returning one beat per accepted ID, with LFSR-driven
//          delay and out-of-order selection. Read data = ID + DATA_OFFSET.
// Macro  : OOO_RESP_IN_ORDER_EN - return IDs in acceptance order (ID FIFO).
// Rev    : 1.0 - initial release
// ============================================================================
module ooo_read_responder #(
    parameter int          DATA_WIDTH  = 8,
    parameter int          ID_WIDTH    = 4,
    parameter int          DATA_OFFSET = 10,
    parameter int          MAX_DELAY   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [ID_WIDTH:0]     pending_cnt_o
);

    localparam int c_DEPTH = 1 << ID_WIDTH;
    localparam int c_CNT_W = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_DEPTH-1:0]    r_pending;
    logic [ID_WIDTH:0]     r_pending_cnt;
    logic [15:0]           r_lfsr;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_ar_fire;
    logic                  w_r_fire;
    logic [c_DEPTH-1:0]    w_set;
    logic [c_DEPTH-1:0]    w_clr;
    logic [c_DEPTH-1:0]    w_pending_next;
    logic [c_CNT_W-1:0]    w_delay_load;
    logic [ID_WIDTH-1:0]   w_sel_id;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_lfsr_fb;

    // Ready is held low during reset so no handshake can land on a clearing table
    assign s_arready_o    = rst_n & ~r_pending[s_arid_i];
    assign w_ar_fire      = s_arvalid_i & s_arready_o;
    assign w_r_fire       = r_rvalid & s_rready_i;
    assign w_set          = {{(c_DEPTH-1){1'b0}}, w_ar_fire} << s_arid_i;
    assign w_clr          = {{(c_DEPTH-1){1'b0}}, w_r_fire} << r_rid;
    assign w_pending_next = (r_pending | w_set) & ~w_clr;

    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_delay_load = c_CNT_W'(32'(r_lfsr[7:0]) % (MAX_DELAY + 1));
    assign w_sel_data   = DATA_WIDTH'(32'(w_sel_id) + DATA_OFFSET);

`ifdef OOO_RESP_IN_ORDER_EN
    logic [ID_WIDTH-1:0] r_fifo [c_DEPTH];
    logic [ID_WIDTH-1:0] r_wr_ptr;
    logic [ID_WIDTH-1:0] r_rd_ptr;

    // Depth equals the ID space, and each ID is outstanding at most once
    always_ff @(posedge clk) begin
        if (w_ar_fire) begin
            r_fifo[r_wr_ptr] <= s_arid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_ar_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_r_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_sel_id = r_fifo[r_rd_ptr];
`else
    always_comb begin
        logic                v_found;
        logic [ID_WIDTH-1:0] v_idx;
        w_sel_id = '0;
        v_found  = 1'b0;
        v_idx    = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            v_idx = r_lfsr[ID_WIDTH-1:0] + ID_WIDTH'(i);
            if (!v_found && r_pending[v_idx]) begin
                w_sel_id = v_idx;
                v_found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_pending_cnt <= '0;
            r_lfsr        <= LFSR_SEED;
            r_cnt         <= '0;
            r_rvalid      <= 1'b0;
            r_rid         <= '0;
            r_rdata       <= '0;
        end else begin
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            r_pending <= w_pending_next;
            if (w_ar_fire && !w_r_fire) begin
                r_pending_cnt <= r_pending_cnt + 1'b1;
            end else if (!w_ar_fire && w_r_fire) begin
                r_pending_cnt <= r_pending_cnt - 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_cnt   <= w_delay_load;
                        r_state <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rid    <= w_sel_id;
                        r_rdata  <= w_sel_data;
                        r_rvalid <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_r_fire) begin
                        r_rvalid <= 1'b0;
                        if (|w_pending_next) begin
                            r_cnt   <= w_delay_load;
                            r_state <= ST_DELAY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_rvalid_o    = r_rvalid;
    assign s_rid_o       = r_rid;
    assign s_rdata_o     = r_rdata;
    assign pending_cnt_o = r_pending_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ooo_read_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_ooo_read_responder
// Desc   : Directed + random self-checking bench for ooo_read_responder.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ooo_read_responder;

    localparam int c_MAXD3 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: 8-bit data, zero delay
    logic [3:0] arid0    = '0;
    logic       arvalid0 = 1'b0;
    logic       rready0  = 1'b0;
    logic       arready0;
    logic [7:0] rdata0;
    logic [3:0] rid0;
    logic       rvalid0;
    logic [4:0] pcnt0;

    // DUT 3: 4-bit data (wrapping), random delay up to 3
    logic [3:0] arid3    = '0;
    logic       arvalid3 = 1'b0;
    logic       rready3  = 1'b0;
    logic       arready3;
    logic [3:0] rdata3;
    logic [3:0] rid3;
    logic       rvalid3;
    logic [4:0] pcnt3;

    ooo_read_responder #(
        .DATA_WIDTH(8), .ID_WIDTH(4), .DATA_OFFSET(10), .MAX_DELAY(0), .LFSR_SEED(16'hACE1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_arid_i(arid0), .s_arvalid_i(arvalid0), .s_arready_o(arready0),
        .s_rdata_o(rdata0), .s_rid_o(rid0), .s_rvalid_o(rvalid0), .s_rready_i(rready0),
        .pending_cnt_o(pcnt0)
    );

    ooo_read_responder #(
        .DATA_WIDTH(4), .ID_WIDTH(4), .DATA_OFFSET(10), .MAX_DELAY(c_MAXD3), .LFSR_SEED(16'h1D2B)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_arid_i(arid3), .s_arvalid_i(arvalid3), .s_arready_o(arready3),
        .s_rdata_o(rdata3), .s_rid_o(rid3), .s_rvalid_o(rvalid3), .s_rready_i(rready3),
        .pending_cnt_o(pcnt3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rvalid0(input string tag);
        int cyc = 0;
        while (!rvalid0 && cyc < 50) begin
            step();
            cyc++;
        end
        if (!rvalid0) check(tag, 32'(rvalid0), 32'd1);
    endtask

    logic [3:0] last_rid0;
    logic [7:0] last_rdata0;

    task automatic collect0(input int n, output logic [15:0] seen, output int bad, output int dup);
        int got = 0;
        int cyc = 0;
        seen = '0;
        bad  = 0;
        dup  = 0;
        while (got < n && cyc < 400) begin
            if (rvalid0 && rready0) begin
                if (seen[rid0]) dup++;
                seen[rid0] = 1'b1;
                if (rdata0 !== ({4'b0, rid0} + 8'd10)) bad++;
                last_rid0   = rid0;
                last_rdata0 = rdata0;
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) check("collect_timeout", 32'(got), 32'(n));
    endtask

    // Scoreboard for DUT 3, sampled on the falling edge
    logic        mon_en     = 1'b0;
    logic [15:0] mon_model  = '0;
    int          mon_gap    = 0;
    logic        mon_hold   = 1'b0;
    logic [3:0]  mon_rid    = '0;
    logic [3:0]  mon_rdata  = '0;
    logic [3:0]  mon_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_model = '0;
            mon_gap   = 0;
            mon_hold  = 1'b0;
            mon_q.delete();
        end else if (mon_en) begin
            if (mon_hold)
                check("r_hold", {23'b0, rvalid3, rid3, rdata3}, {23'b0, 1'b1, mon_rid, mon_rdata});
            check("pending_cnt", 32'(pcnt3), 32'($countones(mon_model)));
            if (arvalid3)
                check("ar_ready", 32'(arready3), 32'(!mon_model[arid3]));
            if (mon_model != '0 && !rvalid3) mon_gap++;
            else mon_gap = 0;
            if (mon_model != '0)
                check("idle_gap_exceeded", 32'(mon_gap > c_MAXD3 + 2), 32'd0);
            if (rvalid3 && rready3) begin
                check("r_id_pending", 32'(mon_model[rid3]), 32'd1);
                check("r_data", 32'(rdata3), (32'(rid3) + 32'd10) % 32'd16);
`ifdef OOO_RESP_IN_ORDER_EN
                if (mon_q.size() > 0) begin
                    check("r_order", 32'(rid3), 32'(mon_q[0]));
                    void'(mon_q.pop_front());
                end
`endif
                mon_model[rid3] = 1'b0;
            end
            if (arvalid3 && arready3) begin
                mon_model[arid3] = 1'b1;
                mon_q.push_back(arid3);
            end
            mon_hold  = rvalid3 && !rready3;
            mon_rid   = rid3;
            mon_rdata = rdata3;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] seen;
        int          bad;
        int          dup;
        logic        any_ready;
        logic        stable;
        logic [3:0]  fr;
        logic [7:0]  fd;
        int          cyc;

        // Reset values
        #2;
        check("rst_arready", 32'(arready0), 32'd0);
        check("rst_rvalid", 32'(rvalid0), 32'd0);
        check("rst_pcnt", 32'(pcnt0), 32'd0);
        check("rst_rid_rdata", {20'b0, rid0, rdata0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_rst_arready", 32'(arready0), 32'd1);
        step();

        // Minimum latency, id 3
        rready0 = 1'b1; arid0 = 4'd3; arvalid0 = 1'b1;
        #1 check("lat_arready", 32'(arready0), 32'd1);
        step();
        arvalid0 = 1'b0;
        check("lat_pcnt1", 32'(pcnt0), 32'd1);
        check("lat_rvalid_n0", 32'(rvalid0), 32'd0);
        step();
        check("lat_rvalid_n1", 32'(rvalid0), 32'd0);
        step();
        check("lat_rvalid_n2", 32'(rvalid0), 32'd1);
        check("lat_rid", 32'(rid0), 32'd3);
        check("lat_rdata", 32'(rdata0), 32'd13);
        step();
        check("lat_done_rvalid", 32'(rvalid0), 32'd0);
        check("lat_pcnt0", 32'(pcnt0), 32'd0);

        // Duplicate ID stalls until its beat completes
        rready0 = 1'b0; arid0 = 4'd5; arvalid0 = 1'b1;
        #1 check("dup_first_ready", 32'(arready0), 32'd1);
        step();
        check("dup_stall", 32'(arready0), 32'd0);
        wait_rvalid0("dup_wait_rvalid");
        check("dup_beat1", {20'b0, rid0, rdata0}, {20'b0, 4'd5, 8'd15});
        check("dup_stall_send", 32'(arready0), 32'd0);
        rready0 = 1'b1;
        step();
        check("dup_ready_after", 32'(arready0), 32'd1);
        step();
        arvalid0 = 1'b0;
        check("dup_pcnt", 32'(pcnt0), 32'd1);
        collect0(1, seen, bad, dup);
        check("dup_beat2", {20'b0, last_rid0, last_rdata0}, {20'b0, 4'd5, 8'd15});
        check("dup_pcnt_end", 32'(pcnt0), 32'd0);

        // Fill all 16 IDs with rready low
        rready0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            arid0 = 4'(i); arvalid0 = 1'b1;
            step();
        end
        arvalid0 = 1'b0;
        check("full_pcnt", 32'(pcnt0), 32'd16);
        any_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            arid0 = 4'(i);
            #1 any_ready = any_ready | arready0;
        end
        check("full_arready", 32'(any_ready), 32'd0);
        step();
        wait_rvalid0("full_wait_rvalid");
        fr = rid0; fd = rdata0; stable = 1'b1;
        repeat (20) begin
            step();
            if (rvalid0 !== 1'b1 || rid0 !== fr || rdata0 !== fd) stable = 1'b0;
        end
        check("full_hold_stable", 32'(stable), 32'd1);
        check("full_first_data", 32'(fd), 32'({4'b0, fr} + 8'd10));
        rready0 = 1'b1;
        collect0(16, seen, bad, dup);
        check("full_all_seen", 32'(seen), 32'h0000_FFFF);
        check("full_bad_data", 32'(bad), 32'd0);
        check("full_dups", 32'(dup), 32'd0);
        step();
        check("full_pcnt_end", 32'(pcnt0), 32'd0);

        // Reset while a beat is presented with 4 IDs pending
        rready0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arid0 = 4'(i); arvalid0 = 1'b1;
            step();
        end
        arvalid0 = 1'b0;
        wait_rvalid0("rst_mid_wait");
        check("rst_mid_pcnt_before", 32'(pcnt0), 32'd4);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid0), 32'd0);
        check("rst_mid_pcnt", 32'(pcnt0), 32'd0);
        check("rst_mid_arready", 32'(arready0), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        arid0 = 4'd7; arvalid0 = 1'b1; rready0 = 1'b1;
        step();
        arvalid0 = 1'b0;
        collect0(1, seen, bad, dup);
        check("rst_mid_beat", {20'b0, last_rid0, last_rdata0}, {20'b0, 4'd7, 8'd17});

        // Data wrap on 4-bit DUT: id 9 + 10 = 19 -> 3
        mon_en = 1'b1;
        arid3 = 4'd9; arvalid3 = 1'b1; rready3 = 1'b0;
        step();
        arvalid3 = 1'b0;
        cyc = 0;
        while (!rvalid3 && cyc < 20) begin
            step();
            cyc++;
        end
        check("wrap_rvalid", 32'(rvalid3), 32'd1);
        check("wrap_rid", 32'(rid3), 32'd9);
        check("wrap_rdata", 32'(rdata3), 32'd3);
        rready3 = 1'b1;
        step();

        // Random traffic
        for (int it = 0; it < 1000; it++) begin
            arid3    = 4'($urandom_range(0, 15));
            arvalid3 = 1'($urandom_range(0, 1));
            rready3  = 1'($urandom_range(0, 1));
            step();
        end
        arvalid3 = 1'b0; rready3 = 1'b1;
        cyc = 0;
        while ((pcnt3 != '0 || rvalid3) && cyc < 300) begin
            step();
            cyc++;
        end
        step();
        check("drain_pcnt", 32'(pcnt3), 32'd0);
        check("drain_model", 32'(mon_model), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
